nist_health_monitor: RTL and testbench
======================================

// Module: nist_health_monitor
// PURPOSE
//  Downstream stage of the NIST statistical test bank on the PUF/TRNG bit stream. Samples
//  each test's free-running pass flag once per test sequence, aggregates them into a per-
//  sequence verdict and tracks fail statistics. Raises a sticky alarm after FAIL_LIMIT
//  consecutive failing sequences; the alarm gates key/response release upstream.
// PARAMETERS
//  NUM_TESTS      4     number of pass_in lines (one per statistical test)
//  SEQ_LEN        2048  cycles per test sequence (n*M of the test bank)
//  SAMPLE_OFFSET  2     cycle within a sequence at which pass_in is sampled (< SEQ_LEN)
//  FAIL_LIMIT     3     consecutive failing sequences that trigger alarm (1..15)
// PORTS
//  clk          in   1          system clock
//  rst          in   1          asynchronous, active-high reset
//  en           in   1          monitor enable; must rise together with test-bank reset release
//  test_en      in   NUM_TESTS  per-test include mask; masked-off tests never cause a fail
//  pass_in      in   NUM_TESTS  pass flags from the test bank, stable at the sample point
//  clear_alarm  in   1          1-cycle request to clear alarm
//  result_valid out  1          1-cycle pulse: new sequence verdict available
//  result_mask  out  NUM_TESTS  latched failing-test mask of last sampled sequence (1 = failed)
//  seq_fail     out  1          verdict of last sequence (|result_mask)
//  seq_count    out  16         sequences evaluated since reset, saturates at 16'hFFFF
//  fail_total   out  16         failing sequences since reset, saturates at 16'hFFFF
//  fail_run     out  4          current consecutive-fail run length, saturates at 15
//  alarm        out  1          sticky health alarm
//  healthy      out  1          1 only in RUN with alarm = 0
// BEHAVIOUR
//  Reset (async): all outputs 0; cyc = 0; state = IDLE.
//  cyc: 0..SEQ_LEN-1 phase counter, width clog2(SEQ_LEN). Counts only in WARMUP/RUN/ALARM,
//   wraps SEQ_LEN-1 -> 0; is 0 in the first cycle after entering WARMUP.
//  Sample point: cyc == SAMPLE_OFFSET in WARMUP/RUN/ALARM.
//  FSM:
//   IDLE   : cyc held 0. en=1 -> WARMUP.
//   WARMUP : first sample is discarded (test bank has no valid result yet); no result_valid,
//            no counter update. At that sample -> RUN.
//   RUN    : each sample: result_mask <= test_en & ~pass_in; result_valid pulses the NEXT
//            cycle together with updated result_mask/seq_fail/seq_count/fail_total/fail_run
//            (latency 1 from sample). fail -> fail_run+1 and fail_total+1; pass -> fail_run=0.
//            If updated fail_run >= FAIL_LIMIT -> alarm=1, state ALARM (same update cycle).
//   ALARM  : keeps sampling and updating counters exactly as RUN; alarm held.
//            clear_alarm with no sample update that cycle -> alarm=0, fail_run=0, state RUN.
//  Simultaneous clear_alarm and a failing update: failure wins, alarm stays 1, fail_run
//   increments; clear is dropped (not queued). With a passing update: clear honoured.
//  clear_alarm in IDLE/WARMUP/RUN: clears alarm if set, else ignored.
//  en=0 in any non-IDLE state (incl. mid-sequence): next cycle -> IDLE; cyc=0; fail_run=0;
//   pending sample discarded; alarm, result_mask, seq_count, fail_total held. Re-enable
//   always passes through WARMUP again.
//  test_en sampled at the sample point only; changes between samples have no effect.
//  Saturating counters never wrap; fail_run saturates at 15 independent of FAIL_LIMIT.
//  healthy is registered: = (state==RUN) & ~alarm.
// TESTING
//  1 reset, en=1, pass_in=4'hF: no result_valid at cyc=2 of seq 0; pulse at cycle
//    SEQ_LEN+3 after en rise; seq_count=1, seq_fail=0, healthy=1.
//  2 pass_in=4'hB, test_en=4'hF for 3 sequences -> result_mask=4'h4, fail_run 1,2,3,
//    alarm=1 on 3rd pulse, healthy=0, fail_total=3.
//  3 same with test_en=4'hB -> result_mask=0, no alarm, fail_run stays 0.
//  4 in ALARM, clear_alarm coincident with failing update -> alarm stays 1, fail_run=4;
//    clear_alarm 10 cycles later -> alarm=0, fail_run=0, healthy=1.
//  5 en=0 at cyc=1000 then en=1 -> next verdict only after a fresh WARMUP sequence;
//    seq_count unchanged across the gap; assert rst mid-sequence -> all outputs 0 at once.
//  6 force seq_count/fail_total to 16'hFFFE, two failing sequences -> both stick at 16'hFFFF.

Source files
------------

// File: rtl/nist_health_monitor.sv
// Purpose : samples the NIST test-bank pass flags once per sequence, builds a per-sequence verdict,
//           keeps saturating fail statistics and raises a sticky alarm after a run of failing sequences.
// Latency : verdict and counters update 1 cycle after the sample point; result_valid pulses in that cycle.
// Backpr. : none - the monitor is free-running and result_valid is a single-cycle strobe.
module nist_health_monitor #(
   parameter int NUM_TESTS     = 4,
   parameter int SEQ_LEN       = 2048,
   parameter int SAMPLE_OFFSET = 2,
   parameter int FAIL_LIMIT    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [NUM_TESTS-1:0] test_en,
   input  logic [NUM_TESTS-1:0] pass_in,
   input  logic                 clear_alarm,
   output logic                 result_valid,
   output logic [NUM_TESTS-1:0] result_mask,
   output logic                 seq_fail,
   output logic [15:0]          seq_count,
   output logic [15:0]          fail_total,
   output logic [3:0]           fail_run,
   output logic                 alarm,
   output logic                 healthy
);

   localparam int CYC_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

   localparam logic [CYC_W-1:0] SAMPLE_PT = CYC_W'(SAMPLE_OFFSET);
   localparam logic [CYC_W-1:0] LAST_CYC  = CYC_W'(SEQ_LEN - 1);
   localparam logic [3:0]       LIMIT     = 4'(FAIL_LIMIT);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] WARMUP = 2'd1;
   localparam logic [1:0] RUN    = 2'd2;
   localparam logic [1:0] ALARM  = 2'd3;

   logic [1:0]           state_q,    state_d;
   logic [CYC_W-1:0]     cyc_q,      cyc_d;
   logic                 valid_q,    valid_d;
   logic [NUM_TESTS-1:0] mask_q,     mask_d;
   logic                 seq_fail_q, seq_fail_d;
   logic [15:0]          cnt_q,      cnt_d;
   logic [15:0]          tot_q,      tot_d;
   logic [3:0]           run_q,      run_d;
   logic                 alarm_q,    alarm_d;
   logic                 healthy_q,  healthy_d;

   logic [NUM_TESTS-1:0] sample_mask;
   logic                 sample_fail;
   logic                 at_sample;
   logic                 at_last;
   logic [3:0]           run_inc;
   logic [15:0]          cnt_inc;
   logic [15:0]          tot_inc;

   // Sample-point decode and saturating increments shared by the next-state logic.
   always_comb begin
      sample_mask = test_en & ~pass_in;
      sample_fail = |sample_mask;
      at_sample   = (cyc_q == SAMPLE_PT);
      at_last     = (cyc_q == LAST_CYC);
      run_inc     = (run_q == 4'hF)     ? run_q : run_q + 4'd1;
      cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      tot_inc     = (tot_q == 16'hFFFF) ? tot_q : tot_q + 16'd1;
   end

   // Next-state logic: phase counter, FSM, verdict, statistics and alarm arbitration.
   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      valid_d    = 1'b0;
      mask_d     = mask_q;
      seq_fail_d = seq_fail_q;
      cnt_d      = cnt_q;
      tot_d      = tot_q;
      run_d      = run_q;
      alarm_d    = alarm_q;

      if (state_q == IDLE) begin
         // Phase is parked at 0 so the first WARMUP cycle starts the sequence at cyc 0.
         cyc_d = '0;
         if (clear_alarm) begin
            alarm_d = 1'b0;
         end
         if (en) begin
            state_d = WARMUP;
         end
      end else if (!en) begin
         // Disable aborts the sequence; statistics and alarm survive, the run does not.
         state_d = IDLE;
         cyc_d   = '0;
         run_d   = 4'd0;
         if (clear_alarm) begin
            alarm_d = 1'b0;
         end
      end else begin
         cyc_d = at_last ? '0 : cyc_q + 1'b1;

         if (state_q == WARMUP) begin
            // Test bank has no valid result in its first sequence: drop that sample.
            if (clear_alarm) begin
               alarm_d = 1'b0;
            end
            if (at_sample) begin
               state_d = RUN;
            end
         end else begin
            // RUN and ALARM sample and account identically.
            if (at_sample) begin
               valid_d    = 1'b1;
               mask_d     = sample_mask;
               seq_fail_d = sample_fail;
               cnt_d      = cnt_inc;
               if (sample_fail) begin
                  tot_d = tot_inc;
                  run_d = run_inc;
               end else begin
                  run_d = 4'd0;
               end
            end

            // A failing update that reaches the limit beats a coincident clear request.
            if (at_sample && sample_fail && (run_inc >= LIMIT)) begin
               alarm_d = 1'b1;
               state_d = ALARM;
            end else if (clear_alarm) begin
               alarm_d = 1'b0;
               if (state_q == ALARM) begin
                  state_d = RUN;
                  run_d   = 4'd0;
               end
            end
         end
      end

      healthy_d = (state_d == RUN) && !alarm_d;
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cyc_q      <= '0;
         valid_q    <= 1'b0;
         mask_q     <= '0;
         seq_fail_q <= 1'b0;
         cnt_q      <= 16'd0;
         tot_q      <= 16'd0;
         run_q      <= 4'd0;
         alarm_q    <= 1'b0;
         healthy_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         valid_q    <= valid_d;
         mask_q     <= mask_d;
         seq_fail_q <= seq_fail_d;
         cnt_q      <= cnt_d;
         tot_q      <= tot_d;
         run_q      <= run_d;
         alarm_q    <= alarm_d;
         healthy_q  <= healthy_d;
      end
   end

   assign result_valid = valid_q;
   assign result_mask  = mask_q;
   assign seq_fail     = seq_fail_q;
   assign seq_count    = cnt_q;
   assign fail_total   = tot_q;
   assign fail_run     = run_q;
   assign alarm        = alarm_q;
   assign healthy      = healthy_q;

endmodule

// File: tb/tb_nist_health_monitor.sv
// Purpose : scoreboard bench for nist_health_monitor; expected verdicts queued at stimulus time.
// Latency : pulses checked at exact cycle offsets (SEQ_LEN+3 after enable, SEQ_LEN period).
// Backpr. : n/a.
module tb_nist_health_monitor;

   logic        clk;
   logic        rst;
   logic        en;
   logic [3:0]  test_en;
   logic [3:0]  pass_in;
   logic        clear_alarm;
   logic        result_valid;
   logic [3:0]  result_mask;
   logic        seq_fail;
   logic [15:0] seq_count;
   logic [15:0] fail_total;
   logic [3:0]  fail_run;
   logic        alarm;
   logic        healthy;

   typedef struct packed {
      logic [3:0]  mask;
      logic        sfail;
      logic [15:0] cnt;
      logic [15:0] tot;
      logic [3:0]  run;
      logic        alarm;
      logic        healthy;
   } exp_t;

   exp_t sb[$];

   int n_chk;
   int n_err;

   logic [15:0] m_cnt;
   logic [15:0] m_tot;
   logic [3:0]  m_run;
   logic        m_alarm;

   nist_health_monitor #(
      .NUM_TESTS(4), .SEQ_LEN(2048), .SAMPLE_OFFSET(2), .FAIL_LIMIT(3)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .test_en(test_en), .pass_in(pass_in),
      .clear_alarm(clear_alarm), .result_valid(result_valid), .result_mask(result_mask),
      .seq_fail(seq_fail), .seq_count(seq_count), .fail_total(fail_total),
      .fail_run(fail_run), .alarm(alarm), .healthy(healthy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model one evaluated sequence and queue its expected verdict.
   task automatic model_push(input logic [3:0] p, input logic [3:0] t);
      exp_t       e;
      logic [3:0] mk;
      mk    = t & ~p;
      m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
      if (|mk) begin
         m_tot = (m_tot == 16'hFFFF) ? m_tot : m_tot + 16'd1;
         m_run = (m_run == 4'hF) ? m_run : m_run + 4'd1;
         if (m_run >= 4'd3) m_alarm = 1'b1;
      end else begin
         m_run = 4'd0;
      end
      e.mask    = mk;
      e.sfail   = |mk;
      e.cnt     = m_cnt;
      e.tot     = m_tot;
      e.run     = m_run;
      e.alarm   = m_alarm;
      e.healthy = ~m_alarm;
      sb.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, result_valid, 0);
      check({tag, "_mask"}, result_mask, 0);
      check({tag, "_sfail"}, seq_fail, 0);
      check({tag, "_cnt"}, seq_count, 0);
      check({tag, "_tot"}, fail_total, 0);
      check({tag, "_run"}, fail_run, 0);
      check({tag, "_alarm"}, alarm, 0);
      check({tag, "_healthy"}, healthy, 0);
   endtask

   // Called at a negedge: raise en and expect the first verdict SEQ_LEN+3 cycles later.
   task automatic enable_and_warm(input logic [3:0] p, input logic [3:0] t);
      int i;
      pass_in = p;
      test_en = t;
      model_push(p, t);
      en = 1'b1;
      for (i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (result_valid) break;
      end
      check("first_pulse_cycle", i, 2051);
   endtask

   // Called at a negedge that is `elapsed` cycles after the previous pulse (cyc = 3+elapsed).
   task automatic do_seq(input logic [3:0] p, input logic [3:0] t, input int elapsed, input logic clr);
      pass_in = p;
      test_en = t;
      model_push(p, t);
      repeat (2047 - elapsed) @(negedge clk);
      if (clr) clear_alarm = 1'b1;
      @(negedge clk);
      clear_alarm = 1'b0;
      check("pulse_period", result_valid, 1);
   endtask

   // Scoreboard consumer: every verdict pulse pops and compares one expected entry.
   always @(negedge clk) begin
      if (!rst && result_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_mask", result_mask, e.mask);
            check("sb_seq_fail", seq_fail, e.sfail);
            check("sb_seq_count", seq_count, e.cnt);
            check("sb_fail_total", fail_total, e.tot);
            check("sb_fail_run", fail_run, e.run);
            check("sb_alarm", alarm, e.alarm);
            check("sb_healthy", healthy, e.healthy);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      m_cnt = 0; m_tot = 0; m_run = 0; m_alarm = 0;
      rst = 1'b1; en = 1'b0; test_en = 4'hF; pass_in = 4'hF; clear_alarm = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Warmup sequence dropped, first passing verdict.
      enable_and_warm(4'hF, 4'hF);

      // Failing test masked off: never a fail.
      repeat (3) do_seq(4'hB, 4'hB, 0, 1'b0);

      // Test 2 failing three times: alarm on the third verdict.
      repeat (3) do_seq(4'hB, 4'hF, 0, 1'b0);

      // Clear coincident with a failing update is dropped.
      do_seq(4'hB, 4'hF, 0, 1'b1);

      // Isolated clear 10 cycles later.
      repeat (10) @(negedge clk);
      clear_alarm = 1'b1;
      @(negedge clk);
      clear_alarm = 1'b0;
      check("clear_alarm", alarm, 0);
      check("clear_run", fail_run, 0);
      check("clear_healthy", healthy, 1);
      m_alarm = 1'b0;
      m_run   = 4'd0;

      // Run restarts from 1 after clear.
      do_seq(4'hB, 4'hF, 11, 1'b0);

      // Disable mid-sequence at cyc 1000.
      repeat (997) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      m_run = 4'd0;
      check("dis_run", fail_run, 0);
      check("dis_healthy", healthy, 0);
      check("dis_mask_held", result_mask, 4'h4);
      repeat (20) @(negedge clk);
      check("dis_cnt_held", seq_count, m_cnt);
      check("dis_tot_held", fail_total, m_tot);
      check("dis_alarm", alarm, 0);

      // Re-enable goes through a fresh warmup.
      enable_and_warm(4'hB, 4'hF);

      // Asynchronous reset mid-sequence.
      repeat (500) @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      #1;
      check_all_zero("midrst");
      m_cnt = 0; m_tot = 0; m_run = 0; m_alarm = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Saturation of the 16-bit counters.
      enable_and_warm(4'hF, 4'hF);
      @(negedge clk);
      force dut.cnt_q = 16'hFFFE;
      force dut.tot_q = 16'hFFFE;
      @(negedge clk);
      release dut.cnt_q;
      release dut.tot_q;
      m_cnt = 16'hFFFE;
      m_tot = 16'hFFFE;
      do_seq(4'hB, 4'hF, 2, 1'b0);
      do_seq(4'hB, 4'hF, 0, 1'b0);

      repeat (5) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
